// File: rtl/bep_pkg.sv
// Shared types and default constants for the frame capture buffer.
// Imported by the shifter and the capture/readout top level.
package bep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int          BEP_FRAME_BITS = 128;
  localparam logic [31:0] BEP_PREAMBLE   = 32'hAAAAAAAA;
  localparam logic [31:0] BEP_CONSTANT   = 32'h0DFFFFFE;

  // Address width for a byte-addressed buffer; never narrower than one bit.
  function automatic int addr_width(input int num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/frame_shift_reg.sv
// Serial-in/parallel-out MSB-first shifter with bit counter, clear and done flag.
// A clear and a shift in the same cycle capture the incoming bit as bit 0.
module frame_shift_reg #(
  parameter  int WIDTH = 128,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_done;

  assign w_done = (r_count == CNT_W'(WIDTH));

  // NOTE: state is written with non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      if (i_shift) begin
        r_data  <= {{(WIDTH-1){1'b0}}, i_bit};
        r_count <= CNT_W'(1);
      end else begin
        r_data  <= '0;
        r_count <= '0;
      end
    end else if (i_shift && !w_done) begin
      r_data  <= {r_data[WIDTH-2:0], i_bit};
      r_count <= r_count + 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;
  assign o_done  = w_done;

endmodule

// File: rtl/frame_capture_buffer.sv
// Assembles decoded bits into a frame, validates preamble and constant field,
// and commits good frames to a byte-addressable shadow buffer with handshaking.
module frame_capture_buffer
  import bep_pkg::*;
#(
  parameter  int                     FRAME_BITS    = BEP_FRAME_BITS,
  parameter  int                     PREAMBLE_BITS = 32,
  parameter  logic [PREAMBLE_BITS-1:0] PREAMBLE    = PREAMBLE_BITS'(BEP_PREAMBLE),
  parameter  bit                     CHECK_EN      = 1'b1,
  parameter  int                     CHECK_POS     = 64,
  parameter  int                     CHECK_BITS    = 32,
  parameter  logic [CHECK_BITS-1:0]  CHECK_VALUE   = CHECK_BITS'(BEP_CONSTANT),
  localparam int                     NUM_BYTES     = FRAME_BITS / 8,
  localparam int                     ADDR_W        = addr_width(NUM_BYTES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              bit_strobe,
  input  logic              bit_data,
  input  logic              hold,
  input  logic              read_ack,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        rd_data,
  output logic              new_frame,
  output logic              overrun,
  output logic              frame_error,
  output logic [7:0]        valid_count
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  if (CHECK_POS + CHECK_BITS > FRAME_BITS) begin : g_bad_check_field
    $error("frame_capture_buffer: constant field extends past the frame");
  end
  if (FRAME_BITS % 8 != 0) begin : g_bad_frame_bits
    $error("frame_capture_buffer: FRAME_BITS must be a multiple of 8");
  end
  if (PREAMBLE_BITS > FRAME_BITS) begin : g_bad_preamble
    $error("frame_capture_buffer: preamble longer than the frame");
  end

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_clear;
  logic                  w_shift;
  logic [FRAME_BITS-1:0] w_frame;
  logic [CNT_W-1:0]      w_count;
  logic                  w_done;
  logic                  w_pre_ok;
  logic                  w_chk_ok;
  logic                  w_ok;
  logic                  w_commit;
  logic                  w_lost;
  logic [FRAME_BITS-1:0] r_shadow;
  logic                  r_new_frame;
  logic                  r_overrun;
  logic                  r_frame_error;
  logic [7:0]            r_valid_count;

  assign w_shift = (r_state == SHIFT) && bit_strobe;

  frame_shift_reg #(.WIDTH(FRAME_BITS)) u_shift (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_clear),
    .i_shift (w_shift),
    .i_bit   (bit_data),
    .o_data  (w_frame),
    .o_count (w_count),
    .o_done  (w_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_clear      = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          w_clear = 1'b1;
        end else if (bit_strobe && !w_done && (w_count == CNT_W'(FRAME_BITS - 1))) begin
          w_next_state = CHECK;
        end
      end
      CHECK: begin
        if (frame_start) begin
          w_clear      = 1'b1;
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Received bit i sits at w_frame[FRAME_BITS-1-i].
  assign w_pre_ok = (w_frame[FRAME_BITS-1 -: PREAMBLE_BITS] == PREAMBLE);
  assign w_chk_ok = !CHECK_EN ||
                    (w_frame[FRAME_BITS-1-CHECK_POS -: CHECK_BITS] == CHECK_VALUE);
  assign w_ok     = w_pre_ok && w_chk_ok;
  assign w_commit = (r_state == CHECK) && w_ok && !hold;
  assign w_lost   = (r_state == CHECK) && w_ok && hold;

  // NOTE: the shadow buffer is a register bank, not RAM, so it is reset to
  // guarantee rd_data reads zero during and after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shadow      <= '0;
      r_new_frame   <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
      r_valid_count <= '0;
    end else begin
      if (r_state == CHECK) r_frame_error <= !w_ok;

      if (w_commit) begin
        r_shadow      <= w_frame;
        r_valid_count <= r_valid_count + 8'd1;
      end

      if (w_commit)      r_new_frame <= 1'b1;
      else if (read_ack) r_new_frame <= 1'b0;

      if (w_lost || (w_commit && r_new_frame && !read_ack)) r_overrun <= 1'b1;
      else if (read_ack)                                    r_overrun <= 1'b0;
    end
  end

  // Byte k holds received bits 8k..8k+7 with the earliest bit in rd_data[7].
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (addr == ADDR_W'(k)) rd_data = r_shadow[FRAME_BITS-1-8*k -: 8];
    end
  end

  assign new_frame   = r_new_frame;
  assign overrun     = r_overrun;
  assign frame_error = r_frame_error;
  assign valid_count = r_valid_count;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Directed self-checking bench for frame_capture_buffer with default parameters.
module tb_frame_capture_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       bit_data = 1'b0;
  logic       hold = 1'b0;
  logic       read_ack = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] rd_data;
  logic       new_frame;
  logic       overrun;
  logic       frame_error;
  logic [7:0] valid_count;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] F1       = {32'hAAAAAAAA, 32'hD391D391, 32'h0DFFFFFE, 32'h12345678};
  localparam logic [127:0] F2       = {32'hAAAAAAAA, 32'hD391D391, 32'h0DFFFFFE, 32'h9ABCDEF0};
  localparam logic [127:0] F_BADPRE = {32'hAAAAAAAB, 32'hD391D391, 32'h0DFFFFFE, 32'h12345678};
  localparam logic [127:0] F_BADCHK = {32'hAAAAAAAA, 32'hD391D391, 32'h0DFFFFFF, 32'h12345678};

  frame_capture_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .bit_strobe  (bit_strobe),
    .bit_data    (bit_data),
    .hold        (hold),
    .read_ack    (read_ack),
    .addr        (addr),
    .rd_data     (rd_data),
    .new_frame   (new_frame),
    .overrun     (overrun),
    .frame_error (frame_error),
    .valid_count (valid_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [127:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bit_strobe = 1'b1;
      bit_data   = f[127-i];
      tick();
    end
    bit_strobe = 1'b0;
  endtask

  // frame_start, 128 strobes, then the CHECK cycle (optionally with read_ack).
  task automatic send_frame(input logic [127:0] f, input logic ack_in_check);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_bits(f, 128);
    read_ack = ack_in_check;
    tick();
    read_ack = 1'b0;
  endtask

  task automatic pulse_ack;
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic read_byte(input logic [3:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1'b1;
    tick();
    if (new_frame !== 1'b0) begin bad++; $display("FAIL reset_new_frame got=%0b exp=0", new_frame); end total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end total++;
    if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error got=%0b exp=0", frame_error); end total++;
    if (valid_count !== 8'd0) begin bad++; $display("FAIL reset_valid_count got=%0d exp=0", valid_count); end total++;
    read_byte(4'd15, d);
    if (d !== 8'h00) begin bad++; $display("FAIL reset_rd15 got=%h exp=00", d); end total++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bad_preamble;
    logic [7:0] d;
    send_frame(F_BADPRE, 1'b0);
    if (frame_error !== 1'b1) begin bad++; $display("FAIL badpre_frame_error got=%0b exp=1", frame_error); end total++;
    if (new_frame !== 1'b0) begin bad++; $display("FAIL badpre_new_frame got=%0b exp=0", new_frame); end total++;
    if (valid_count !== 8'd0) begin bad++; $display("FAIL badpre_valid_count got=%0d exp=0", valid_count); end total++;
    read_byte(4'd0, d);
    if (d !== 8'h00) begin bad++; $display("FAIL badpre_rd0 got=%h exp=00", d); end total++;
    read_byte(4'd15, d);
    if (d !== 8'h00) begin bad++; $display("FAIL badpre_rd15 got=%h exp=00", d); end total++;
  endtask

  task automatic test_valid_frame;
    logic [7:0] d;
    send_frame(F1, 1'b0);
    if (new_frame !== 1'b1) begin bad++; $display("FAIL valid_new_frame got=%0b exp=1", new_frame); end total++;
    if (frame_error !== 1'b0) begin bad++; $display("FAIL valid_frame_error got=%0b exp=0", frame_error); end total++;
    if (valid_count !== 8'd1) begin bad++; $display("FAIL valid_valid_count got=%0d exp=1", valid_count); end total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL valid_overrun got=%0b exp=0", overrun); end total++;
    read_byte(4'd0, d);
    if (d !== 8'hAA) begin bad++; $display("FAIL valid_rd0 got=%h exp=aa", d); end total++;
    read_byte(4'd4, d);
    if (d !== 8'hD3) begin bad++; $display("FAIL valid_rd4 got=%h exp=d3", d); end total++;
    read_byte(4'd8, d);
    if (d !== 8'h0D) begin bad++; $display("FAIL valid_rd8 got=%h exp=0d", d); end total++;
    read_byte(4'd15, d);
    if (d !== 8'h78) begin bad++; $display("FAIL valid_rd15 got=%h exp=78", d); end total++;
    pulse_ack();
    if (new_frame !== 1'b0) begin bad++; $display("FAIL valid_ack_new_frame got=%0b exp=0", new_frame); end total++;
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    apply_reset();
    send_frame(F1, 1'b0);
    send_frame(F2, 1'b0);
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_overrun got=%0b exp=1", overrun); end total++;
    if (new_frame !== 1'b1) begin bad++; $display("FAIL ovr_new_frame got=%0b exp=1", new_frame); end total++;
    if (valid_count !== 8'd2) begin bad++; $display("FAIL ovr_valid_count got=%0d exp=2", valid_count); end total++;
    read_byte(4'd15, d);
    if (d !== 8'hF0) begin bad++; $display("FAIL ovr_rd15 got=%h exp=f0", d); end total++;
    read_byte(4'd12, d);
    if (d !== 8'h9A) begin bad++; $display("FAIL ovr_rd12 got=%h exp=9a", d); end total++;
    pulse_ack();
    if (new_frame !== 1'b0) begin bad++; $display("FAIL ovr_ack_new_frame got=%0b exp=0", new_frame); end total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_ack_overrun got=%0b exp=0", overrun); end total++;
  endtask

  task automatic test_hold;
    logic [7:0] d;
    addr = 4'd15;
    hold = 1'b1;
    send_frame(F1, 1'b0);
    if (rd_data !== 8'hF0) begin bad++; $display("FAIL hold_rd15 got=%h exp=f0", rd_data); end total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL hold_overrun got=%0b exp=1", overrun); end total++;
    if (valid_count !== 8'd2) begin bad++; $display("FAIL hold_valid_count got=%0d exp=2", valid_count); end total++;
    if (new_frame !== 1'b0) begin bad++; $display("FAIL hold_new_frame got=%0b exp=0", new_frame); end total++;
    if (frame_error !== 1'b0) begin bad++; $display("FAIL hold_frame_error got=%0b exp=0", frame_error); end total++;
    hold = 1'b0;
    pulse_ack();
    if (overrun !== 1'b0) begin bad++; $display("FAIL hold_ack_overrun got=%0b exp=0", overrun); end total++;
    read_byte(4'd15, d);
    if (d !== 8'hF0) begin bad++; $display("FAIL hold_after_rd15 got=%h exp=f0", d); end total++;
  endtask

  task automatic test_ack_same_cycle;
    logic [7:0] d;
    send_frame(F1, 1'b0);
    if (valid_count !== 8'd3) begin bad++; $display("FAIL ackc_first_count got=%0d exp=3", valid_count); end total++;
    send_frame(F2, 1'b1);
    if (new_frame !== 1'b1) begin bad++; $display("FAIL ackc_new_frame got=%0b exp=1", new_frame); end total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ackc_overrun got=%0b exp=0", overrun); end total++;
    if (valid_count !== 8'd4) begin bad++; $display("FAIL ackc_valid_count got=%0d exp=4", valid_count); end total++;
    read_byte(4'd15, d);
    if (d !== 8'hF0) begin bad++; $display("FAIL ackc_rd15 got=%h exp=f0", d); end total++;
    pulse_ack();
  endtask

  task automatic test_bad_check_field;
    logic [7:0] d;
    send_frame(F_BADCHK, 1'b0);
    if (frame_error !== 1'b1) begin bad++; $display("FAIL badchk_frame_error got=%0b exp=1", frame_error); end total++;
    if (valid_count !== 8'd4) begin bad++; $display("FAIL badchk_valid_count got=%0d exp=4", valid_count); end total++;
    if (new_frame !== 1'b0) begin bad++; $display("FAIL badchk_new_frame got=%0b exp=0", new_frame); end total++;
    read_byte(4'd15, d);
    if (d !== 8'hF0) begin bad++; $display("FAIL badchk_rd15 got=%h exp=f0", d); end total++;
  endtask

  task automatic test_restart;
    logic [7:0] d;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_bits(F_BADPRE, 50);
    send_frame(F1, 1'b0);
    if (valid_count !== 8'd5) begin bad++; $display("FAIL restart_valid_count got=%0d exp=5", valid_count); end total++;
    if (frame_error !== 1'b0) begin bad++; $display("FAIL restart_frame_error got=%0b exp=0", frame_error); end total++;
    if (new_frame !== 1'b1) begin bad++; $display("FAIL restart_new_frame got=%0b exp=1", new_frame); end total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL restart_overrun got=%0b exp=0", overrun); end total++;
    read_byte(4'd0, d);
    if (d !== 8'hAA) begin bad++; $display("FAIL restart_rd0 got=%h exp=aa", d); end total++;
    read_byte(4'd15, d);
    if (d !== 8'h78) begin bad++; $display("FAIL restart_rd15 got=%h exp=78", d); end total++;
    send_bits(F2, 8);
    tick();
    if (valid_count !== 8'd5) begin bad++; $display("FAIL idle_strobe_count got=%0d exp=5", valid_count); end total++;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_bits(F1, 70);
    reset = 1'b1;
    #1;
    if (new_frame !== 1'b0) begin bad++; $display("FAIL midrst_new_frame got=%0b exp=0", new_frame); end total++;
    if (valid_count !== 8'd0) begin bad++; $display("FAIL midrst_valid_count got=%0d exp=0", valid_count); end total++;
    read_byte(4'd0, d);
    if (d !== 8'h00) begin bad++; $display("FAIL midrst_rd0 got=%h exp=00", d); end total++;
    tick();
    reset = 1'b0;
    tick();
    send_frame(F1, 1'b0);
    if (valid_count !== 8'd1) begin bad++; $display("FAIL midrst_after_count got=%0d exp=1", valid_count); end total++;
    if (new_frame !== 1'b1) begin bad++; $display("FAIL midrst_after_new_frame got=%0b exp=1", new_frame); end total++;
    if (frame_error !== 1'b0) begin bad++; $display("FAIL midrst_after_frame_error got=%0b exp=0", frame_error); end total++;
    read_byte(4'd0, d);
    if (d !== 8'hAA) begin bad++; $display("FAIL midrst_after_rd0 got=%h exp=aa", d); end total++;
  endtask

  initial begin
    test_reset();
    test_bad_preamble();
    test_valid_frame();
    test_overrun();
    test_hold();
    test_ack_same_cycle();
    test_bad_check_field();
    test_restart();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_capture_buffer.md
Name: frame_capture_buffer

Overview:
Parametrised successor to the fixed-field thermostat capture/readout logic. Takes the decoded bit stream (strobe plus data) and the transmission-start pulse from the Manchester state machine, and assembles a frame of FRAME_BITS. It validates the preamble and one constant field, then commits valid frames to a shadow buffer. The shadow buffer is byte-addressable for the microcontroller and adds hold, new-frame and overrun handshaking so reads are never torn.

Parameters:
FRAME_BITS, 128, total frame length in bits; must be a multiple of 8 and ≥ PREAMBLE_BITS.
PREAMBLE_BITS, 32, length of the leading preamble field.
PREAMBLE, 32'hAAAAAAAA, required preamble value; the LSB-aligned PREAMBLE_BITS bits are used.
CHECK_EN, 1, 1 = enable the constant-field check.
CHECK_POS, 64, received-bit index of the first constant-field bit (bit 0 = first received bit).
CHECK_BITS, 32, width of the constant field.
CHECK_VALUE, 32'h0DFFFFFE, required constant-field value.
NUM_BYTES, FRAME_BITS/8, derived; do not override.
ADDR_W, $clog2(NUM_BYTES), derived read-address width.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
frame_start  in  1  one-cycle pulse marking transmission begin.
bit_strobe  in  1  one-cycle pulse; bit_data is valid this cycle.
bit_data  in  1  decoded bit.
hold  in  1  1 = MCU reading; shadow buffer must not change.
read_ack  in  1  one-cycle pulse; clears new_frame and overrun.
addr  in  ADDR_W  byte select for the shadow buffer.
rd_data  out  8  selected shadow byte (combinational from addr).
new_frame  out  1  unread valid frame present in the shadow buffer.
overrun  out  1  a valid frame was lost or overwrote an unread one.
frame_error  out  1  the most recently completed frame failed validation.
valid_count  out  8  count of committed frames; wraps 255→0.

Behaviour:
- Reset (asynchronous): state IDLE; shift register, bit counter and shadow buffer all 0; new_frame, overrun and frame_error 0; valid_count 0. rd_data = 0 during reset.
- States:
  - IDLE: bit_strobe is ignored. frame_start → SHIFT with count = 0.
  - SHIFT: on bit_strobe, shift MSB-first so the first received bit ends up at frame bit FRAME_BITS-1; count++. When count reaches FRAME_BITS → CHECK. frame_start in SHIFT restarts the frame: count = 0, stay in SHIFT; a bit_strobe in the same cycle is captured as bit 0.
  - CHECK: lasts one cycle, then → IDLE, or → SHIFT with count 0 if frame_start is asserted in this cycle. Strobes during CHECK are dropped.
- Validation (evaluated in CHECK):
  - pre_ok = first PREAMBLE_BITS received bits == PREAMBLE.
  - chk_ok = !CHECK_EN, or received bits [CHECK_POS .. CHECK_POS+CHECK_BITS-1] == CHECK_VALUE.
  - ok = pre_ok & chk_ok.
  - frame_error <= !ok.
- Commit (in CHECK, when ok & !hold):
  - Shadow buffer <= shift register; new_frame <= 1; valid_count++.
  - If new_frame was 1 and read_ack is 0 this cycle → overrun <= 1.
- ok & hold: shadow buffer unchanged, overrun <= 1, valid_count unchanged.
- read_ack: new_frame <= 0 and overrun <= 0, except that a same-cycle commit wins for new_frame (stays 1) and does not set overrun.
- Readout: byte k = received bits [8k .. 8k+7], first received bit in rd_data[7]. addr ≥ NUM_BYTES → rd_data = 0. rd_data changes only on commit or addr change, never while hold = 1.
- Extra bit_strobes after FRAME_BITS bits are ignored until the next frame_start. A frame truncated by reset is discarded.
- Elaboration-time assertions: CHECK_POS+CHECK_BITS ≤ FRAME_BITS; FRAME_BITS % 8 == 0.

Decomposition:
- Package bep_pkg: state enum (IDLE, SHIFT, CHECK); default constants BEP_PREAMBLE = 32'hAAAAAAAA and BEP_CONSTANT = 32'h0DFFFFFE; BEP_FRAME_BITS = 128.
- One sub-module: frame_shift_reg, a parametrised serial-in/parallel-out shifter with bit counter, clear input and done flag.
- Validation and byte mux stay in the top module.

Test Plan:
- Reset, then a 128-bit frame: AAAAAAAA, D391D391, 0DFFFFFE, 12345678 → 1 cycle after the 128th strobe: new_frame = 1, frame_error = 0, valid_count = 1; addr 0 → 0xAA, addr 8 → 0x0D, addr 15 → 0x78.
- Same frame with preamble AAAAAAAB → frame_error = 1, new_frame = 0, shadow buffer still 0.
- Two valid frames without read_ack (second ends ...9ABCDEF0) → overrun = 1, addr 15 = 0xF0, valid_count = 2; read_ack → new_frame = 0, overrun = 0.
- hold = 1 across a valid frame → addr 15 keeps its old value, overrun = 1, valid_count unchanged.
- frame_start after 50 bits, then a full valid frame → a single commit with correct bytes, no frame_error.
- Reset asserted mid-frame (bit 70), then a full frame → outputs 0 during reset; the next frame commits normally with valid_count = 1.
